// File: rtl/pred_pkg.sv
// Shared definitions for the intra-prediction mode selector: default geometry,
// source index constants, FSM state type and the flat sample-offset helper.
package pred_pkg;

  localparam int DEF_BLK  = 4;
  localparam int DEF_BW   = 8;
  localparam int DEF_NSRC = 3;

  localparam int SRC_DC     = 0;
  localparam int SRC_PLANAR = 1;
  localparam int SRC_ANG    = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Bit offset of sample (s,r,c) inside the flat candidate bus.
  function automatic int sample_off(input int s, input int r, input int c,
                                    input int blk, input int bw);
    return ((s * blk + r) * blk + c) * bw;
  endfunction

endpackage

// File: rtl/pred_blk_buf.sv
// Block buffer: BLK rows of BLK*BW bits, written as a whole block in one cycle
// and read one row at a time through a row-indexed mux.
module pred_blk_buf
  import pred_pkg::*;
#(
  parameter int BLK = DEF_BLK,
  parameter int BW  = DEF_BW,
  parameter int RIW = (BLK > 1) ? $clog2(BLK) : 1
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [BLK*BLK*BW-1:0]  wr_blk,
  input  logic [RIW-1:0]         rd_row,
  output logic [BLK*BW-1:0]      rd_data
);

  localparam int ROW_W = BLK * BW;

  logic [ROW_W-1:0] rows_q [BLK];
  logic [ROW_W-1:0] rows_d [BLK];

  always_comb begin
    for (int r = 0; r < BLK; r++) begin
      rows_d[r] = wr_en ? wr_blk[r*ROW_W +: ROW_W] : rows_q[r];
    end
  end

  // NOTE: the sample storage has no reset on purpose; its contents are only
  // observed after a capture, so resetting it would just add reset fan-out.
  always_ff @(posedge clk) begin
    for (int r = 0; r < BLK; r++) begin
      rows_q[r] <= rows_d[r];
    end
  end

  assign rd_data = rows_q[rd_row];

endmodule

// File: rtl/pred_mode_sel_stream.sv
// Captures the MODE_SEL-chosen candidate block and streams it out row by row
// under valid/ready. Optional OUT_MODE tag port: define PRED_MODE_TAG_EN.
module pred_mode_sel_stream
  import pred_pkg::*;
#(
  parameter int  BLK  = DEF_BLK,
  parameter int  BW   = DEF_BW,
  parameter int  NSRC = DEF_NSRC,
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int RIW  = (BLK > 1) ? $clog2(BLK) : 1
) (
  input  logic                       CLK_LOW,
  input  logic                       RST_N,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [SELW-1:0]            MODE_SEL,
  input  logic [NSRC*BLK*BLK*BW-1:0] PRED_IN,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [BLK*BW-1:0]          OUT_ROW,
  output logic [RIW-1:0]             OUT_ROW_IDX,
  output logic                       OUT_LAST,
`ifdef PRED_MODE_TAG_EN
  output logic [SELW-1:0]            OUT_MODE,
`endif
  output logic                       ERR_SEL
);

  localparam int              ROW_W    = BLK * BW;
  localparam int              BLK_W    = BLK * ROW_W;
  localparam logic [RIW-1:0]  ROW_LAST = RIW'(BLK - 1);

  state_e           state_q, state_d;
  logic [RIW-1:0]   row_q, row_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             in_ready;
  logic             accept;
  logic             sel_ok;
  logic [BLK_W-1:0] cand_blk;

  assign sel_ok   = int'(MODE_SEL) < NSRC;
  assign in_ready = (state_q == IDLE) || (last_q && OUT_READY);
  assign accept   = IN_VALID && in_ready;

  // Out-of-range selections fall back to the DC source.
  always_comb begin
    cand_blk = PRED_IN[sample_off(SRC_DC, 0, 0, BLK, BW) +: BLK_W];
    for (int s = 1; s < NSRC; s++) begin
      if (int'(MODE_SEL) == s) begin
        cand_blk = PRED_IN[sample_off(s, 0, 0, BLK, BW) +: BLK_W];
      end
    end
  end

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    last_d  = last_q;
    valid_d = valid_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          state_d = STREAM;
          row_d   = '0;
          last_d  = (BLK == 1);
          valid_d = 1'b1;
        end
      end
      STREAM: begin
        if (OUT_READY) begin
          if (!last_q) begin
            row_d  = row_q + RIW'(1);
            last_d = (row_q + RIW'(1)) == ROW_LAST;
          end else if (IN_VALID) begin
            row_d  = '0;
            last_d = (BLK == 1);
          end else begin
            state_d = IDLE;
            row_d   = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
        last_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    if (accept && !sel_ok) begin
      err_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_LOW or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      row_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

`ifdef PRED_MODE_TAG_EN
  logic [SELW-1:0] mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (accept) begin
      mode_d = sel_ok ? MODE_SEL : '0;
    end
  end

  always_ff @(posedge CLK_LOW or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= '0;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign OUT_MODE = mode_q;
`endif

  pred_blk_buf #(
    .BLK (BLK),
    .BW  (BW),
    .RIW (RIW)
  ) u_buf (
    .clk     (CLK_LOW),
    .wr_en   (accept),
    .wr_blk  (cand_blk),
    .rd_row  (row_q),
    .rd_data (OUT_ROW)
  );

  assign IN_READY    = in_ready;
  assign OUT_VALID   = valid_q;
  assign OUT_ROW_IDX = row_q;
  assign OUT_LAST    = last_q;
  assign ERR_SEL     = err_q;

endmodule

// File: tb/tb_pred_mode_sel_stream.sv
// Directed bench for pred_mode_sel_stream at BLK=4, BW=8, NSRC=3: table of
// whole-block vectors plus stall, back-to-back and mid-stream reset sequences.
module tb_pred_mode_sel_stream;

  localparam int BLK  = 4;
  localparam int BW   = 8;
  localparam int NSRC = 3;
  localparam int NVEC = 5;

  typedef logic [3:0][31:0] rows_t;

  // Source s sample (r,c): src0 = 0x80+16r+c, src1 = 16r+c, src2 = 0x40+16r+c.
  localparam rows_t SRC0_ROWS = {32'hB3B2B1B0, 32'hA3A2A1A0, 32'h93929190, 32'h83828180};
  localparam rows_t SRC1_ROWS = {32'h33323130, 32'h23222120, 32'h13121110, 32'h03020100};
  localparam rows_t SRC2_ROWS = {32'h73727170, 32'h63626160, 32'h53525150, 32'h43424140};

  typedef struct {
    logic [1:0] mode;
    rows_t      rows;
    logic       err;
    logic [1:0] tag;
  } vec_t;

  logic         clk_low;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode_sel;
  logic [383:0] pred_in;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_row;
  logic [1:0]   out_row_idx;
  logic         out_last;
  logic         err_sel;
`ifdef PRED_MODE_TAG_EN
  logic [1:0]   out_mode;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pred_mode_sel_stream #(
    .BLK  (BLK),
    .BW   (BW),
    .NSRC (NSRC)
  ) dut (
    .CLK_LOW     (clk_low),
    .RST_N       (rst_n),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .MODE_SEL    (mode_sel),
    .PRED_IN     (pred_in),
    .OUT_VALID   (out_valid),
    .OUT_READY   (out_ready),
    .OUT_ROW     (out_row),
    .OUT_ROW_IDX (out_row_idx),
    .OUT_LAST    (out_last),
`ifdef PRED_MODE_TAG_EN
    .OUT_MODE    (out_mode),
`endif
    .ERR_SEL     (err_sel)
  );

  initial clk_low = 1'b0;
  always #5 clk_low = ~clk_low;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_low);
    #1;
  endtask

  task automatic load_pattern();
    for (int s = 0; s < NSRC; s++) begin
      for (int r = 0; r < BLK; r++) begin
        for (int c = 0; c < BLK; c++) begin
          logic [7:0] base;
          base = (s == 0) ? 8'h80 : (s == 1) ? 8'h00 : 8'h40;
          pred_in[((s*BLK + r)*BLK + c)*BW +: BW] = base + 8'(16*r + c);
        end
      end
    end
  endtask

  task automatic scramble();
    for (int k = 0; k < 12; k++) pred_in[k*32 +: 32] = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int budget = 20;
    while (!(in_ready && !out_valid) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check({name, "_idle_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic check_row(input string name, input logic [31:0] row,
                           input int idx, input logic last);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_row"}, 64'(out_row), 64'(row));
    check({name, "_idx"}, 64'(out_row_idx), 64'(idx));
    check({name, "_last"}, 64'(out_last), 64'(last));
  endtask

  vec_t vecs [NVEC];

  initial begin
    vecs[0] = '{mode: 2'd1, rows: SRC1_ROWS, err: 1'b0, tag: 2'd1};
    vecs[1] = '{mode: 2'd0, rows: SRC0_ROWS, err: 1'b0, tag: 2'd0};
    vecs[2] = '{mode: 2'd2, rows: SRC2_ROWS, err: 1'b0, tag: 2'd2};
    vecs[3] = '{mode: 2'd3, rows: SRC0_ROWS, err: 1'b1, tag: 2'd0};
    vecs[4] = '{mode: 2'd1, rows: SRC1_ROWS, err: 1'b1, tag: 2'd1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode_sel  = '0;
    out_ready = 1'b1;
    pred_in   = '0;
    #22;
    rst_n = 1'b1;
    tick();

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_err_sel", 64'(err_sel), 64'd0);
    check("rst_row_idx", 64'(out_row_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);

    // Table: one whole block per vector with OUT_READY held high.
    for (int v = 0; v < NVEC; v++) begin
      wait_idle($sformatf("vec%0d", v));
      check($sformatf("vec%0d_in_ready", v), 64'(in_ready), 64'd1);
      load_pattern();
      mode_sel = vecs[v].mode;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      scramble();
      for (int r = 0; r < BLK; r++) begin
        check_row($sformatf("vec%0d_r%0d", v, r), vecs[v].rows[r], r, r == BLK - 1);
`ifdef PRED_MODE_TAG_EN
        check($sformatf("vec%0d_r%0d_mode", v, r), 64'(out_mode), 64'(vecs[v].tag));
`endif
        if (r == BLK - 1) check($sformatf("vec%0d_last_in_ready", v), 64'(in_ready), 64'd1);
        tick();
      end
      check($sformatf("vec%0d_done_valid", v), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d_done_in_ready", v), 64'(in_ready), 64'd1);
      check($sformatf("vec%0d_err", v), 64'(err_sel), 64'(vecs[v].err));
    end

    // Stall three cycles on row 1.
    wait_idle("stall");
    load_pattern();
    mode_sel = 2'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble();
    check_row("stall_r0", SRC1_ROWS[0], 0, 1'b0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_row($sformatf("stall_hold%0d", k), SRC1_ROWS[1], 1, 1'b0);
      check($sformatf("stall_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check_row("stall_r2", SRC1_ROWS[2], 2, 1'b0);
    tick();
    check_row("stall_r3", SRC1_ROWS[3], 3, 1'b1);
    tick();
    check("stall_done_valid", 64'(out_valid), 64'd0);

    // Back-to-back: source 0 then source 2 with IN_VALID held high.
    wait_idle("b2b");
    load_pattern();
    mode_sel = 2'd0;
    in_valid = 1'b1;
    tick();
    mode_sel = 2'd2;
    for (int r = 0; r < BLK; r++) begin
      check_row($sformatf("b2b_a_r%0d", r), SRC0_ROWS[r], r, r == BLK - 1);
      check($sformatf("b2b_a_r%0d_in_ready", r), 64'(in_ready), 64'(r == BLK - 1));
      tick();
    end
    in_valid = 1'b0;
    scramble();
    for (int r = 0; r < BLK; r++) begin
      check_row($sformatf("b2b_b_r%0d", r), SRC2_ROWS[r], r, r == BLK - 1);
      tick();
    end
    check("b2b_done_valid", 64'(out_valid), 64'd0);
    check("b2b_err_sticky", 64'(err_sel), 64'd1);

    // Asynchronous reset at row 2.
    wait_idle("arst");
    load_pattern();
    mode_sel = 2'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_row("arst_r2", SRC1_ROWS[2], 2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_async_valid", 64'(out_valid), 64'd0);
    check("arst_async_err", 64'(err_sel), 64'd0);
    check("arst_async_idx", 64'(out_row_idx), 64'd0);
    tick();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("arst_after%0d_valid", k), 64'(out_valid), 64'd0);
      check($sformatf("arst_after%0d_in_ready", k), 64'(in_ready), 64'd1);
      check($sformatf("arst_after%0d_idx", k), 64'(out_row_idx), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pred_mode_sel_stream.md
Name: pred_mode_sel_stream

Overview:
- Parametrised successor to the registered DC/angular output selector in the intra-prediction datapath.
- Accepts NSRC candidate prediction blocks (e.g. DC, planar, angular) of BLK x BLK samples, each BW bits, in parallel.
- Captures the candidate chosen by MODE_SEL into an internal block buffer, then streams it out one row per beat under a valid/ready handshake.
- Sits between the per-mode predictors and the residual/reconstruction stage.

Parameters:
- BLK, 4, block edge in samples (4, 8, 16, 32).
- BW, 8, sample bit width.
- NSRC, 3, number of candidate predictor sources (index 0 = DC, 1 = planar, 2 = angular by convention).
- SELW, $clog2(NSRC) (min 1), width of MODE_SEL; derived, not overridden.
- RIW, $clog2(BLK) (min 1), row index width; derived.

Ports:
- CLK_LOW  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  candidate set and MODE_SEL valid.
- IN_READY  out  1  block accepted when IN_VALID and IN_READY are both high at a rising edge.
- MODE_SEL  in  SELW  source index to capture.
- PRED_IN  in  NSRC*BLK*BLK*BW  flat candidates; sample (s,r,c) at bit offset ((s*BLK+r)*BLK+c)*BW.
- OUT_VALID  out  1  OUT_ROW valid.
- OUT_READY  in  1  downstream accepts the row.
- OUT_ROW  out  BLK*BW  current row; column c at bit offset c*BW.
- OUT_ROW_IDX  out  RIW  current row number.
- OUT_LAST  out  1  high with row BLK-1.
- ERR_SEL  out  1  sticky flag: a block was accepted with MODE_SEL >= NSRC.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FSM goes to IDLE; row counter 0.
  - OUT_VALID, OUT_LAST, OUT_ROW_IDX and ERR_SEL all 0.
  - Buffer contents undefined; OUT_ROW is don't-care while OUT_VALID = 0.
- FSM states: IDLE, STREAM.
- IDLE:
  - IN_READY = 1, OUT_VALID = 0.
  - On accept: copy source MODE_SEL into the buffer, set row = 0, go to STREAM.
- STREAM:
  - OUT_VALID = 1; OUT_ROW = buffer row `row`; OUT_ROW_IDX = row; OUT_LAST = (row == BLK-1).
  - Row advances only on OUT_VALID && OUT_READY.
  - OUT_ROW, OUT_ROW_IDX and OUT_LAST stay stable while stalled.
  - IN_READY = OUT_LAST && OUT_READY (combinational).
- Last-row handshake, when the last row is accepted:
  - If IN_VALID is also high: capture the new block in the same edge, stay in STREAM, row = 0. This gives back-to-back blocks with no bubble.
  - Otherwise: go to IDLE.
- Latency and throughput:
  - Row 0 is presented in the cycle after acceptance.
  - Sustained throughput is one block per BLK cycles when OUT_READY is held high.
- Out-of-range MODE_SEL (only possible when NSRC is not a power of 2):
  - Source 0 is captured.
  - ERR_SEL sets on that edge and holds until reset.
- The buffer is written only on accept; PRED_IN may change freely at all other times.
- Reset mid-stream: output drops immediately (OUT_VALID = 0); the partial block is discarded with no replay.
- No arithmetic is performed; samples pass bit-exact.

Optional Feature:
- Macro: PRED_MODE_TAG_EN.
- When defined:
  - Adds output OUT_MODE [SELW], holding the MODE_SEL captured with the block (0 when out of range), constant across all rows of that block.
  - Resets to 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package pred_pkg holds:
  - localparams for default BLK/BW/NSRC;
  - source index constants SRC_DC = 0, SRC_PLANAR = 1, SRC_ANG = 2;
  - the FSM state typedef (IDLE/STREAM);
  - a sample-offset helper function.
- One natural sub-module: pred_blk_buf. It holds the BLK*BLK*BW storage with a whole-block write port and a row-indexed read mux.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- Reset, then idle: OUT_VALID = 0, IN_READY = 1, ERR_SEL = 0, OUT_ROW_IDX = 0.
- BLK = 4, BW = 8. Source 1 sample (r,c) = 16*r+c, MODE_SEL = 1, OUT_READY held 1:
  - rows arrive on 4 consecutive cycles starting 1 cycle after accept;
  - row 2 = {0x23, 0x22, 0x21, 0x20} (col 3 .. col 0);
  - OUT_LAST only on row 3.
- Stall: OUT_READY low for 3 cycles at row 1:
  - row 1 data, OUT_ROW_IDX = 1 and OUT_LAST = 0 held stable;
  - IN_READY stays 0;
  - streaming resumes at row 2 after release.
- Back-to-back: IN_VALID high with MODE_SEL = 0 then 2 across 2 blocks:
  - 8 consecutive valid rows, no gap;
  - the second block's row 0 appears the cycle after the first block's row 3 is accepted.
- NSRC = 3, MODE_SEL = 3:
  - source 0 data streamed;
  - ERR_SEL = 1 and stays 1 through later good blocks until RST_N is pulsed.
- RST_N asserted at row 2:
  - OUT_VALID drops in the same cycle, asynchronously;
  - after release the block is IDLE, IN_READY = 1, and no stale row is emitted.
